// File: rtl/carry_lookahead_adder16_xor_enc32_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : carry_lookahead_adder16_xor_enc32_pkg
//  Description : Shared constants for the key-locked 16-bit two-level
//                carry-lookahead adder: default unlock key, datapath widths,
//                the key-bit-to-net mapping, and the key-gate helper.
//  Revision    : 1.0  initial release
// ============================================================================
package carry_lookahead_adder16_xor_enc32_pkg;

    // Unlocking key. Gate k is an XOR where bit k is 0, an XNOR where it is 1.
    localparam logic [31:0] c_KEY_CORRECT = 32'hF17B83DB;

    localparam int c_DATA_W = 16;
    localparam int c_KEY_W  = 32;
    localparam int c_RES_W  = 17;

    // Propagate bits that carry a key gate; the gating key bit index equals
    // the propagate bit index. Bits 2, 7 and 15 stay ungated because key
    // bits 2, 7 and 15 are spent on the sum-bit cascades instead.
    localparam logic [15:0] c_P_GATE_MASK = 16'h7F7B;

    // Generate bits g[0]..g[c_G_GATED_N-1] are gated by key bits starting here.
    localparam int c_G_KEY_BASE = 16;
    localparam int c_G_GATED_N  = 14;

    // Carry-out gate, applied after the lookahead logic.
    localparam int c_COUT_KEY = 31;

    // Two-gate cascades on sum bits; flipping both bits of a pair cancels.
    localparam int c_SUM2_KEY_A = 2;
    localparam int c_SUM2_KEY_B = 30;
    localparam int c_SUM7_KEY_A = 7;
    localparam int c_SUM7_KEY_B = 15;

    // Transparent when key_bit equals correct_bit, inverting otherwise.
    function automatic logic key_gate(input logic net_in,
                                      input logic key_bit,
                                      input logic correct_bit);
        return net_in ^ key_bit ^ correct_bit;
    endfunction

endpackage
`default_nettype wire

// File: rtl/carry_lookahead_adder16_xor_enc32_cla4.sv
`default_nettype none
// ============================================================================
//  Module      : cla4_block
//  Description : 4-bit carry-lookahead group. Takes (possibly key-gated)
//                propagate/generate bits and a group carry-in; produces the
//                four in-group carries and the group propagate/generate.
//  Ports       : i_p[3:0], i_g[3:0] - bit propagate / generate
//                i_cin             - carry into bit 0 of the group
//                o_c[3:0]          - carries into bits 0..3 (o_c[0] = i_cin)
//                o_grp_p, o_grp_g  - group propagate / generate
//  Revision    : 1.0  initial release
// ============================================================================
module cla4_block (
    input  logic [3:0] i_p,
    input  logic [3:0] i_g,
    input  logic       i_cin,
    output logic [3:0] o_c,
    output logic       o_grp_p,
    output logic       o_grp_g
);

    assign o_c[0] = i_cin;
    assign o_c[1] = i_g[0] | (i_p[0] & i_cin);
    assign o_c[2] = i_g[1] | (i_p[1] & i_g[0]) | (i_p[1] & i_p[0] & i_cin);
    assign o_c[3] = i_g[2] | (i_p[2] & i_g[1]) | (i_p[2] & i_p[1] & i_g[0])
                  | (i_p[2] & i_p[1] & i_p[0] & i_cin);

    assign o_grp_p = &i_p;
    assign o_grp_g = i_g[3] | (i_p[3] & i_g[2]) | (i_p[3] & i_p[2] & i_g[1])
                   | (i_p[3] & i_p[2] & i_p[1] & i_g[0]);

endmodule
`default_nettype wire

// File: rtl/carry_lookahead_adder16_xor_enc32.sv
`default_nettype none
// ============================================================================
//  Module      : carry_lookahead_adder16_xor_enc32
//  Description : Key-locked 16-bit adder with two-level carry lookahead and
//                a registered 17-bit result. With the correct key the result
//                is add1_i + add2_i one clock later; any other key yields the
//                deterministic value of the gated netlist.
//  Ports       : clk_i     - clock, rising edge
//                rst_i     - synchronous active-high reset, clears result_o
//                add1_i    - addend A (unsigned, 16 bits)
//                add2_i    - addend B (unsigned, 16 bits)
//                keyinput  - applied key (32 bits), sampled every cycle
//                result_o  - registered {carry_out, sum[15:0]}
//  Revision    : 1.0  initial release
// ============================================================================
module carry_lookahead_adder16_xor_enc32
    import carry_lookahead_adder16_xor_enc32_pkg::*;
#(
    parameter logic [31:0] KEY_CORRECT = c_KEY_CORRECT
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic [c_DATA_W-1:0] add1_i,
    input  logic [c_DATA_W-1:0] add2_i,
    input  logic [c_KEY_W-1:0]  keyinput,
    output logic [c_RES_W-1:0]  result_o
);

    logic [c_DATA_W-1:0] w_p_raw;
    logic [c_DATA_W-1:0] w_g_raw;
    logic [c_DATA_W-1:0] w_p;
    logic [c_DATA_W-1:0] w_g;
    logic [c_DATA_W-1:0] w_c;
    logic [3:0]          w_grp_p;
    logic [3:0]          w_grp_g;
    logic [3:0]          w_grp_cin;
    logic                w_cout;
    logic                w_cout_gated;
    logic [c_DATA_W-1:0] w_sum_raw;
    logic [c_DATA_W-1:0] w_sum;
    logic                w_sum2_mid;
    logic                w_sum7_mid;
    logic [c_RES_W-1:0]  r_result;

    assign w_p_raw = add1_i ^ add2_i;
    assign w_g_raw = add1_i & add2_i;

    // Gated propagate feeds both the lookahead network and the sum XOR.
    generate
        for (genvar i = 0; i < c_DATA_W; i++) begin : g_p_gate
            if (c_P_GATE_MASK[i]) begin : g_gated
                assign w_p[i] = key_gate(w_p_raw[i], keyinput[i], KEY_CORRECT[i]);
            end else begin : g_pass
                assign w_p[i] = w_p_raw[i];
            end
        end

        for (genvar i = 0; i < c_DATA_W; i++) begin : g_g_gate
            if (i < c_G_GATED_N) begin : g_gated
                assign w_g[i] = key_gate(w_g_raw[i],
                                         keyinput[c_G_KEY_BASE + i],
                                         KEY_CORRECT[c_G_KEY_BASE + i]);
            end else begin : g_pass
                assign w_g[i] = w_g_raw[i];
            end
        end

        for (genvar j = 0; j < 4; j++) begin : g_grp
            cla4_block u_cla4 (
                .i_p     (w_p[4*j +: 4]),
                .i_g     (w_g[4*j +: 4]),
                .i_cin   (w_grp_cin[j]),
                .o_c     (w_c[4*j +: 4]),
                .o_grp_p (w_grp_p[j]),
                .o_grp_g (w_grp_g[j])
            );
        end
    endgenerate

    // Second-level lookahead: group carries from group P/G, carry-in is 0.
    assign w_grp_cin[0] = 1'b0;
    assign w_grp_cin[1] = w_grp_g[0] | (w_grp_p[0] & w_grp_cin[0]);
    assign w_grp_cin[2] = w_grp_g[1] | (w_grp_p[1] & w_grp_g[0])
                        | (w_grp_p[1] & w_grp_p[0] & w_grp_cin[0]);
    assign w_grp_cin[3] = w_grp_g[2] | (w_grp_p[2] & w_grp_g[1])
                        | (w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                        | (w_grp_p[2] & w_grp_p[1] & w_grp_p[0] & w_grp_cin[0]);
    assign w_cout       = w_grp_g[3] | (w_grp_p[3] & w_grp_g[2])
                        | (w_grp_p[3] & w_grp_p[2] & w_grp_g[1])
                        | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_g[0])
                        | (w_grp_p[3] & w_grp_p[2] & w_grp_p[1] & w_grp_p[0]
                           & w_grp_cin[0]);

    assign w_cout_gated = key_gate(w_cout, keyinput[c_COUT_KEY], KEY_CORRECT[c_COUT_KEY]);

    assign w_sum_raw = w_p ^ w_c;

    // Cascaded gate pairs on sum bits 2 and 7.
    assign w_sum2_mid = key_gate(w_sum_raw[2], keyinput[c_SUM2_KEY_A], KEY_CORRECT[c_SUM2_KEY_A]);
    assign w_sum7_mid = key_gate(w_sum_raw[7], keyinput[c_SUM7_KEY_A], KEY_CORRECT[c_SUM7_KEY_A]);

    always_comb begin
        w_sum    = w_sum_raw;
        w_sum[2] = key_gate(w_sum2_mid, keyinput[c_SUM2_KEY_B], KEY_CORRECT[c_SUM2_KEY_B]);
        w_sum[7] = key_gate(w_sum7_mid, keyinput[c_SUM7_KEY_B], KEY_CORRECT[c_SUM7_KEY_B]);
    end

    // Output register is the only storage in the block.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_result <= '0;
        end else begin
            r_result <= {w_cout_gated, w_sum};
        end
    end

    assign result_o = r_result;

endmodule
`default_nettype wire

// File: tb/tb_carry_lookahead_adder16_xor_enc32.sv
`default_nettype none
// ============================================================================
//  Module      : tb_carry_lookahead_adder16_xor_enc32
//  Description : Self-checking bench for the key-locked 16-bit CLA adder.
//                Directed vectors plus randomized operands/keys/resets
//                compared against a ripple-carry behavioural model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_carry_lookahead_adder16_xor_enc32;

    localparam logic [31:0] KEY_OK  = 32'hF17B83DB;
    localparam logic [31:0] KEY_ALT1 = 32'hB17B83DF;
    localparam logic [31:0] KEY_ALT2 = 32'hF17B035B;

    logic        clk = 1'b0;
    logic        rst_i;
    logic [15:0] add1_i;
    logic [15:0] add2_i;
    logic [31:0] keyinput;
    logic [16:0] result_o;

    int n_checks = 0;
    int n_errors = 0;

    logic [16:0] prev_exp;
    bit          have_prev = 1'b0;

    always #5 clk = ~clk;

    carry_lookahead_adder16_xor_enc32 #(
        .KEY_CORRECT (KEY_OK)
    ) dut (
        .clk_i    (clk),
        .rst_i    (rst_i),
        .add1_i   (add1_i),
        .add2_i   (add2_i),
        .keyinput (keyinput),
        .result_o (result_o)
    );

    task automatic check_eq(input string tag, input logic [16:0] obs, input logic [16:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Behavioural model: apply each wrong key bit as an inversion of its
    // net, then add with a plain ripple carry.
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic [31:0] key);
        logic [31:0] d;
        logic [15:0] p;
        logic [15:0] g;
        logic [15:0] s;
        logic        c;
        d = key ^ KEY_OK;
        p = a ^ b;
        g = a & b;
        for (int k = 0; k < 16; k++)
            if (k != 2 && k != 7 && k != 15) p[k] = p[k] ^ d[k];
        for (int k = 0; k < 14; k++) g[k] = g[k] ^ d[16 + k];
        c = 1'b0;
        for (int i = 0; i < 16; i++) begin
            s[i] = p[i] ^ c;
            c    = g[i] | (p[i] & c);
        end
        s[2] = s[2] ^ d[2] ^ d[30];
        s[7] = s[7] ^ d[7] ^ d[15];
        c    = c ^ d[31];
        return {c, s};
    endfunction

    // Drive on the falling edge, confirm the output still holds the previous
    // result, then sample one rising edge later.
    task automatic apply(input logic [15:0] a, input logic [15:0] b, input logic [31:0] key,
                         input logic rst, input string tag, input logic [16:0] exp,
                         output logic [16:0] got);
        @(negedge clk);
        add1_i   = a;
        add2_i   = b;
        keyinput = key;
        rst_i    = rst;
        #1;
        if (have_prev) check_eq({tag, "_hold"}, result_o, prev_exp);
        @(posedge clk);
        #1;
        got       = result_o;
        prev_exp  = exp;
        have_prev = 1'b1;
        check_eq(tag, result_o, exp);
    endtask

    logic [15:0] vec_a [7] = '{16'h29AF, 16'h8943, 16'h5555, 16'h0000, 16'hFFFF, 16'h1024, 16'h0000};
    logic [15:0] vec_b [7] = '{16'h7A1B, 16'hFFFF, 16'hAAAA, 16'h0001, 16'hFFFF, 16'h8192, 16'h0000};
    logic [16:0] vec_s [7] = '{17'h0A3CA, 17'h18942, 17'h0FFFF, 17'h00001, 17'h1FFFE, 17'h091B6, 17'h00000};
    logic [31:0] bad_keys [3] = '{32'hF17B83CB, 32'hF37B83DB, 32'hF17BC3DB};

    initial begin
        logic [16:0] got;
        logic [31:0] k;
        logic [15:0] ra;
        logic [15:0] rb;
        logic        rr;
        int          n_diff;

        rst_i    = 1'b1;
        add1_i   = '0;
        add2_i   = '0;
        keyinput = KEY_OK;

        // Reset held while an operand pair is presented, then released.
        apply(16'h29AF, 16'h7A1B, KEY_OK, 1'b1, "reset", 17'h0, got);
        apply(16'h29AF, 16'h7A1B, KEY_OK, 1'b0, "post_reset", 17'h0A3CA, got);

        // Directed vectors with the correct key and both equivalent keys.
        for (int i = 0; i < 7; i++) apply(vec_a[i], vec_b[i], KEY_OK,   1'b0, "key_ok",   vec_s[i], got);
        for (int i = 0; i < 7; i++) apply(vec_a[i], vec_b[i], KEY_ALT1, 1'b0, "key_alt1", vec_s[i], got);
        for (int i = 0; i < 7; i++) apply(vec_a[i], vec_b[i], KEY_ALT2, 1'b0, "key_alt2", vec_s[i], got);

        // Single wrong key bits with known results.
        apply(16'h0000, 16'h0000, 32'hF17B83DA, 1'b0, "bad_bit0",  17'h00001, got);
        apply(16'h0000, 16'h0000, 32'h717B83DB, 1'b0, "bad_bit31", 17'h10000, got);

        // Wrong keys must corrupt at least one of the directed pairs.
        for (int kk = 0; kk < 3; kk++) begin
            n_diff = 0;
            for (int i = 0; i < 7; i++) begin
                apply(vec_a[i], vec_b[i], bad_keys[kk], 1'b0, "bad_key_model",
                      model(vec_a[i], vec_b[i], bad_keys[kk]), got);
                if (got !== vec_s[i]) n_diff++;
            end
            check_eq("bad_key_detect", 17'(n_diff != 0), 17'h1);
        end

        // Reset asserted mid-stream discards the pending result.
        apply(16'h1234, 16'h1111, KEY_OK, 1'b0, "stream_a", 17'h02345, got);
        apply(16'hF000, 16'h1000, KEY_OK, 1'b1, "stream_rst", 17'h0, got);
        apply(16'hF000, 16'h1000, KEY_OK, 1'b0, "stream_b", 17'h10000, got);

        // Randomized operands, keys and occasional resets.
        for (int n = 0; n < 400; n++) begin
            ra = 16'($urandom);
            rb = 16'($urandom);
            case ($urandom_range(0, 5))
                0, 1:    k = KEY_OK;
                2:       k = KEY_ALT1;
                3:       k = KEY_ALT2;
                4:       k = KEY_OK ^ (32'h1 << $urandom_range(0, 31));
                default: k = $urandom;
            endcase
            rr = ($urandom_range(0, 15) == 0);
            apply(ra, rb, k, rr, "random", rr ? 17'h0 : model(ra, rb, k), got);
            if (!rr && (k == KEY_OK || k == KEY_ALT1 || k == KEY_ALT2))
                check_eq("random_sum", got, {1'b0, ra} + {1'b0, rb});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
